// File: rtl/mssb_rr_arbiter.sv
// Round-robin arbiter: descending-index scan from below the last accepted grant,
// winner offered over valid/ready with optional locked multi-beat ownership.
module mssb_rr_arbiter #(
   parameter int WIDTH = 7,
   parameter int IDXW  = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_cg,
   input  logic [WIDTH-1:0] i_req,
   input  logic             i_lock,
   input  logic             i_ready,
   output logic             o_valid,
   output logic [IDXW-1:0]  o_index,
   output logic [WIDTH-1:0] o_grant,
   output logic             o_locked
);

   // state  | meaning
   // IDLE   | no grant offered or held
   // OFFER  | o_index offered, waiting for i_ready or withdrawal
   // LOCKED | grantee owns the resource across multiple beats
   typedef enum logic [1:0] {IDLE, OFFER, LOCKED} state_t;

   state_t           state_q, state_d;
   logic             ptr_valid_q, ptr_valid_d;
   logic [IDXW-1:0]  last_idx_q, last_idx_d;
   logic             valid_q, valid_d;
   logic [IDXW-1:0]  index_q, index_d;
   logic [WIDTH-1:0] grant_q, grant_d;
   logic             locked_q, locked_d;
   logic [IDXW-1:0]  win;

   function automatic logic [IDXW-1:0] mssb(input logic [WIDTH-1:0] v);
      logic [IDXW-1:0] r;
      r = '0;
      for (int i = 0; i < WIDTH; i++)
         if (v[i]) r = IDXW'(i);
      return r;
   endfunction

   // Requests strictly below the pointer take precedence; otherwise wrap to the top.
   function automatic logic [IDXW-1:0] pick(input logic [WIDTH-1:0] req,
                                            input logic pv,
                                            input logic [IDXW-1:0] last);
      logic [WIDTH-1:0] below;
      below = '0;
      for (int i = 0; i < WIDTH; i++)
         if (pv && (i < int'(last))) below[i] = req[i];
      return (below != '0) ? mssb(below) : mssb(req);
   endfunction

   always_comb begin
      state_d     = state_q;
      ptr_valid_d = ptr_valid_q;
      last_idx_d  = last_idx_q;
      valid_d     = valid_q;
      index_d     = index_q;
      grant_d     = grant_q;
      locked_d    = locked_q;
      win         = '0;
      case (state_q)
         IDLE: begin
            if (|i_req) begin
               win     = pick(i_req, ptr_valid_q, last_idx_q);
               index_d = win;
               grant_d = WIDTH'(1) << win;
               valid_d = 1'b1;
               state_d = OFFER;
            end
         end
         OFFER: begin
            if (i_ready) begin
               last_idx_d  = index_q;
               ptr_valid_d = 1'b1;
               if (i_lock && i_req[index_q]) begin
                  state_d  = LOCKED;
                  valid_d  = 1'b0;
                  locked_d = 1'b1;
               end else if (|i_req) begin
                  win     = pick(i_req, 1'b1, index_q);
                  index_d = win;
                  grant_d = WIDTH'(1) << win;
               end else begin
                  state_d = IDLE;
                  valid_d = 1'b0;
                  grant_d = '0;
               end
            end else if (!i_req[index_q]) begin
               state_d = IDLE;
               valid_d = 1'b0;
               grant_d = '0;
            end
         end
         LOCKED: begin
            if (!(i_lock && i_req[index_q])) begin
               state_d  = IDLE;
               locked_d = 1'b0;
               grant_d  = '0;
            end
         end
         default: begin
            state_d  = IDLE;
            valid_d  = 1'b0;
            grant_d  = '0;
            locked_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= IDLE;
         ptr_valid_q <= 1'b0;
         last_idx_q  <= '0;
         valid_q     <= 1'b0;
         index_q     <= '0;
         grant_q     <= '0;
         locked_q    <= 1'b0;
      end else if (i_cg) begin
         state_q     <= state_d;
         ptr_valid_q <= ptr_valid_d;
         last_idx_q  <= last_idx_d;
         valid_q     <= valid_d;
         index_q     <= index_d;
         grant_q     <= grant_d;
         locked_q    <= locked_d;
      end
   end

   assign o_valid  = valid_q;
   assign o_index  = index_q;
   assign o_grant  = grant_q;
   assign o_locked = locked_q;

endmodule

// File: tb/tb_mssb_rr_arbiter.sv
// Directed bench for mssb_rr_arbiter with hand-computed expectations.
module tb_mssb_rr_arbiter;
   localparam int WIDTH = 7;
   localparam int IDXW  = 3;

   logic             clk;
   logic             rst_n;
   logic             cg;
   logic [WIDTH-1:0] req;
   logic             lock;
   logic             ready;
   logic             valid;
   logic [IDXW-1:0]  index;
   logic [WIDTH-1:0] grant;
   logic             locked;

   int errors = 0;
   int checks = 0;

   mssb_rr_arbiter #(.WIDTH(WIDTH)) dut (
      .i_clk    (clk),
      .i_rst_n  (rst_n),
      .i_cg     (cg),
      .i_req    (req),
      .i_lock   (lock),
      .i_ready  (ready),
      .o_valid  (valid),
      .o_index  (index),
      .o_grant  (grant),
      .o_locked (locked)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic invariants();
      logic [WIDTH-1:0] oh;
      oh = WIDTH'(1) << index;
      check("valid_locked_excl", {31'd0, valid & locked}, 32'd0);
      if (valid | locked)
         check("grant_onehot", {25'd0, grant}, {25'd0, oh});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      invariants();
   endtask

   task automatic expect_offer(input string tag, input logic [IDXW-1:0] idx,
                               input logic [WIDTH-1:0] g);
      check({tag, "_valid"}, {31'd0, valid}, 32'd1);
      check({tag, "_index"}, {29'd0, index}, {29'd0, idx});
      check({tag, "_grant"}, {25'd0, grant}, {25'd0, g});
      check({tag, "_locked"}, {31'd0, locked}, 32'd0);
   endtask

   task automatic expect_all_zero(input string tag);
      check({tag, "_valid"}, {31'd0, valid}, 32'd0);
      check({tag, "_index"}, {29'd0, index}, 32'd0);
      check({tag, "_grant"}, {25'd0, grant}, 32'd0);
      check({tag, "_locked"}, {31'd0, locked}, 32'd0);
   endtask

   initial begin
      logic [IDXW-1:0] seq [6];
      logic [WIDTH-1:0] gseq [6];
      seq  = '{3'd6, 3'd4, 3'd1, 3'd6, 3'd4, 3'd1};
      gseq = '{7'b1000000, 7'b0010000, 7'b0000010, 7'b1000000, 7'b0010000, 7'b0000010};

      rst_n = 1'b0; cg = 1'b1; req = '0; lock = 1'b0; ready = 1'b0;
      #12;
      expect_all_zero("reset");
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         expect_all_zero("idle_noreq");
      end

      // Back-to-back round robin 6,4,1,6,4,1
      req = 7'b1010010; ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         expect_offer("rr_seq", seq[i], gseq[i]);
      end
      req = '0; ready = 1'b0;   // withdraw offered 1; pointer stays at 4
      tick();
      check("rr_withdraw_valid", {31'd0, valid}, 32'd0);
      check("rr_withdraw_grant", {25'd0, grant}, 32'd0);

      // Offer 4, withdraw, re-request 6|4 -> 6 since pointer still 4
      req = 7'b0010000;
      tick();
      expect_offer("w_offer4", 3'd4, 7'b0010000);
      req = '0;
      tick();
      check("w_drop_valid", {31'd0, valid}, 32'd0);
      req = 7'b1010000;
      tick();
      expect_offer("w_rereq", 3'd6, 7'b1000000);
      req = '0;
      tick();
      check("w_drop2_valid", {31'd0, valid}, 32'd0);

      // Stable offer while new request appears
      req = 7'b1000000;
      tick();
      expect_offer("stable_c1", 3'd6, 7'b1000000);
      req = 7'b1100000;
      for (int i = 0; i < 4; i++) begin
         tick();
         expect_offer("stable_hold", 3'd6, 7'b1000000);
      end
      ready = 1'b1;
      tick();
      expect_offer("stable_next", 3'd5, 7'b0100000);
      ready = 1'b0; req = '0;
      tick();
      check("stable_drop_valid", {31'd0, valid}, 32'd0);

      // Lock on acceptance of index 4 (pointer at 6)
      req = 7'b0010010;
      tick();
      expect_offer("lk_offer", 3'd4, 7'b0010000);
      ready = 1'b1; lock = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         check("lk_locked", {31'd0, locked}, 32'd1);
         check("lk_valid", {31'd0, valid}, 32'd0);
         check("lk_index", {29'd0, index}, 32'd4);
         check("lk_grant", {25'd0, grant}, 32'h10);
      end
      lock = 1'b0; ready = 1'b0;
      tick();
      check("lk_rel_locked", {31'd0, locked}, 32'd0);
      check("lk_rel_valid", {31'd0, valid}, 32'd0);
      check("lk_rel_grant", {25'd0, grant}, 32'd0);
      tick();
      expect_offer("lk_after", 3'd1, 7'b0000010);

      // Clock gate freezes an offer even with ready high and request gone
      cg = 1'b0; ready = 1'b1; req = 7'b1010000;
      for (int i = 0; i < 4; i++) begin
         tick();
         expect_offer("cg_frozen", 3'd1, 7'b0000010);
      end

      // Async reset mid-cycle, then first grant is plain mssb
      #3;
      rst_n = 1'b0;
      #1;
      expect_all_zero("async_rst");
      cg = 1'b1; ready = 1'b0; req = 7'b0010010;
      #2;
      rst_n = 1'b1;
      tick();
      expect_offer("post_rst", 3'd4, 7'b0010000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule
